// File: rtl/eth_frame_loop_tx.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_loop_tx
// Description : TX-side consumer of the frame-detector loop FIFO. For every
//               frame it pulls one control word, then either drops the frame
//               bytes or forwards them to the TX MAC through a one-stage
//               register slice. While forwarding, it patches the IPv4 header
//               checksum and the L4 checksum in place. Frames flagged
//               FCS_INVALID are marked on the tlast beat via tuser.
// Ports       : clk, rst_n           - TX clock, synchronous active-low reset
//               enable               - gates the start of new frames only
//               s_axis_frame_*       - frame bytes from the loop FIFO
//               s_axis_ctl_*         - 48-bit per-frame control word
//               m_axis_*             - byte stream to the TX MAC
//               count_tx/count_drop  - sent / dropped frame counters
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_loop_tx #(
   parameter int C_CNT_WIDTH   = 32,
   parameter int C_IP_CSUM_POS = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [7:0]             s_axis_frame_tdata,
   input  logic                   s_axis_frame_tlast,
   input  logic                   s_axis_frame_tvalid,
   output logic                   s_axis_frame_tready,
   input  logic [47:0]            s_axis_ctl_tdata,
   input  logic                   s_axis_ctl_tvalid,
   output logic                   s_axis_ctl_tready,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tuser,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [C_CNT_WIDTH-1:0] count_tx,
   output logic [C_CNT_WIDTH-1:0] count_drop
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   // 15-bit compare space so that position+1 never wraps onto index 0
   localparam logic [14:0] c_ip_hi   = 15'(C_IP_CSUM_POS);
   localparam logic [14:0] c_ip_lo   = 15'(C_IP_CSUM_POS + 1);
   localparam logic [13:0] c_idx_max = 14'h3FFF;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [47:0]            r_ctl;
   logic [13:0]            r_idx;
   logic [7:0]             r_m_tdata;
   logic                   r_m_tuser;
   logic                   r_m_tlast;
   logic                   r_m_tvalid;
   logic [C_CNT_WIDTH-1:0] r_count_tx;
   logic [C_CNT_WIDTH-1:0] r_count_drop;

   logic                   w_frame_tready;
   logic                   w_ctl_tready;
   logic                   w_in_hs;
   logic                   w_out_hs;
   logic [7:0]             w_byte;
   logic [14:0]            w_idx;
   logic [14:0]            w_pos_hi;
   logic [14:0]            w_pos_lo;
   logic                   w_l4_en;
   logic                   w_ip_en;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_frame_tready = 1'b0;
      w_ctl_tready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s_axis_ctl_tvalid && enable) begin
               w_ctl_tready = 1'b1;
               w_state_next = s_axis_ctl_tdata[1] ? ST_DROP : ST_SEND;
            end
         end
         ST_SEND: begin
            // register slice: accept whenever the output stage is empty or draining
            w_frame_tready = ~r_m_tvalid | m_axis_tready;
            if (s_axis_frame_tvalid && w_frame_tready && s_axis_frame_tlast) begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // output stage holds the tlast beat until the MAC takes it
            if (r_m_tvalid && m_axis_tready) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_DROP: begin
            w_frame_tready = 1'b1;
            if (s_axis_frame_tvalid && s_axis_frame_tlast) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_in_hs  = s_axis_frame_tvalid & w_frame_tready;
   assign w_out_hs = r_m_tvalid & m_axis_tready;

   // ------------------------------------------------------------------------
   // Checksum patching; the L4 patch is applied last so it wins on overlap
   // ------------------------------------------------------------------------
   assign w_idx    = {1'b0, r_idx};
   assign w_pos_hi = {1'b0, r_ctl[15:2]};
   assign w_pos_lo = w_pos_hi + 15'd1;
   assign w_l4_en  = |r_ctl[15:2];
   assign w_ip_en  = |r_ctl[47:32];

   always_comb begin
      w_byte = s_axis_frame_tdata;
      if (w_ip_en && (w_idx == c_ip_hi)) begin
         w_byte = r_ctl[47:40];
      end else if (w_ip_en && (w_idx == c_ip_lo)) begin
         w_byte = r_ctl[39:32];
      end
      if (w_l4_en && (w_idx == w_pos_hi)) begin
         w_byte = r_ctl[31:24];
      end else if (w_l4_en && (w_idx == w_pos_lo)) begin
         w_byte = r_ctl[23:16];
      end
   end

   // ------------------------------------------------------------------------
   // Datapath: control latch, byte index, output slice, counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ctl        <= '0;
         r_idx        <= '0;
         r_m_tdata    <= '0;
         r_m_tuser    <= 1'b0;
         r_m_tlast    <= 1'b0;
         r_m_tvalid   <= 1'b0;
         r_count_tx   <= '0;
         r_count_drop <= '0;
      end else begin
         if (w_ctl_tready) begin
            r_ctl <= s_axis_ctl_tdata;
            r_idx <= '0;
         end

         if (w_in_hs && (r_state == ST_SEND)) begin
            r_m_tdata  <= w_byte;
            r_m_tlast  <= s_axis_frame_tlast;
            r_m_tuser  <= s_axis_frame_tlast & r_ctl[0];
            r_m_tvalid <= 1'b1;
            if (r_idx != c_idx_max) begin
               r_idx <= r_idx + 14'd1;
            end
         end else if (w_out_hs) begin
            r_m_tvalid <= 1'b0;
         end

         if ((r_state == ST_FLUSH) && w_out_hs) begin
            r_count_tx <= r_count_tx + C_CNT_WIDTH'(1);
         end

         if ((r_state == ST_DROP) && w_in_hs && s_axis_frame_tlast) begin
            r_count_drop <= r_count_drop + C_CNT_WIDTH'(1);
         end
      end
   end

   // Handshakes are combinational from state; hold them low while in reset
   assign s_axis_frame_tready = w_frame_tready & rst_n;
   assign s_axis_ctl_tready   = w_ctl_tready & rst_n;
   assign m_axis_tdata        = r_m_tdata;
   assign m_axis_tuser        = r_m_tuser;
   assign m_axis_tlast        = r_m_tlast;
   assign m_axis_tvalid       = r_m_tvalid;
   assign count_tx            = r_count_tx;
   assign count_drop          = r_count_drop;

endmodule
`default_nettype wire

// File: doc/eth_frame_loop_tx.md
Name: eth_frame_loop_tx

Overview:
- Transmit-side consumer of the frame-detector loop FIFO; pulls one control word and its frame bytes per frame and emits a byte stream to the TX MAC.
- Drops frames marked DROP_FRAME, including overflow-truncated ones.
- Patches the IPv4 header checksum and the L4 checksum.
- Flags FCS_INVALID frames to the MAC via tuser.
- Sits entirely in the TX clock domain, after the FIFO clock crossing.

Parameters:
- C_CNT_WIDTH, 32, width of the sent/dropped frame counters.
- C_IP_CSUM_POS, 24, byte offset of the IPv4 header checksum MSB (Ethernet header 14 + IPv4 offset 10).

Ports:
- clk  in  1  TX clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  when low, no new frame is started; the current frame completes.
- s_axis_frame_tdata  in  8  frame byte from the loop FIFO.
- s_axis_frame_tlast  in  1  last byte of frame.
- s_axis_frame_tvalid  in  1  byte valid.
- s_axis_frame_tready  out  1  byte accepted.
- s_axis_ctl_tdata  in  48  [0] FCS_INVALID, [1] DROP_FRAME, [15:2] CSUM_POS, [31:16] CSUM_VAL, [47:32] IP_CSUM.
- s_axis_ctl_tvalid  in  1  control word valid; asserted only once the whole frame is in the frame FIFO.
- s_axis_ctl_tready  out  1  control word consumed.
- m_axis_tdata  out  8  output byte.
- m_axis_tuser  out  1  on the tlast beat: request the MAC to corrupt the FCS.
- m_axis_tlast  out  1  last output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  MAC ready.
- count_tx  out  C_CNT_WIDTH  frames fully sent.
- count_drop  out  C_CNT_WIDTH  frames dropped.

Behaviour:
- Reset values: state=ST_IDLE; s_axis_frame_tready=0, s_axis_ctl_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, count_tx=0, count_drop=0; byte index=0; control register=0.
- ST_IDLE:
  - When s_axis_ctl_tvalid & enable, latch the control word, pulse s_axis_ctl_tready for that cycle and reset byte index to 0.
  - Next state: ST_DROP if DROP_FRAME=1, else ST_SEND.
  - Frame bytes are never consumed in ST_IDLE.
- ST_SEND:
  - Output is a one-stage register slice: s_axis_frame_tready = ~m_axis_tvalid | m_axis_tready.
  - On each input handshake, load the output register with the possibly patched byte and tlast, set m_axis_tvalid, and increment the index (saturating at 16383).
  - Latency is 1 cycle input to output.
  - m_axis_tvalid clears when the downstream handshake completes and no new byte is loaded.
- Patching, by index of the input byte (0-based):
  - If CSUM_POS≠0: index==CSUM_POS outputs CSUM_VAL[15:8]; index==CSUM_POS+1 outputs CSUM_VAL[7:0].
  - If IP_CSUM≠0: index==C_IP_CSUM_POS outputs IP_CSUM[15:8]; index==C_IP_CSUM_POS+1 outputs IP_CSUM[7:0].
  - If both regions overlap, the L4 patch wins.
  - A position at or beyond the frame length has no effect.
- m_axis_tuser = FCS_INVALID, on the tlast beat only; 0 on all other beats.
- On input tlast handshake in ST_SEND, go to ST_FLUSH.
- ST_FLUSH:
  - s_axis_frame_tready=0.
  - When the tlast output beat handshakes, increment count_tx and go to ST_IDLE.
  - Back-to-back frames therefore have at least one idle cycle between them.
- ST_DROP:
  - s_axis_frame_tready=1; bytes are discarded and outputs are untouched.
  - On tlast handshake, increment count_drop and go to ST_IDLE.
- Counters wrap modulo 2^C_CNT_WIDTH.
- enable falling mid-frame has no effect until return to ST_IDLE.
- Reset mid-frame: all state clears; the remaining bytes of the interrupted frame are not resynchronised by this block, because the upstream FIFOs share the reset.
- Invalid state encoding: go to ST_IDLE.

Test Plan:
- 64-byte frame 00..3F, ctl=0 -> 64 output bytes identical, tlast on byte 63, tuser=0, count_tx=1, one ctl_tready pulse.
- Same frame, ctl with CSUM_POS=40, CSUM_VAL=16'hBEEF, IP_CSUM=16'h1234 -> byte24=12, byte25=34, byte40=BE, byte41=EF, all others unchanged.
- ctl=48'h2 (DROP_FRAME) with a 100-byte frame, followed by a normal 60-byte frame -> no output for the first frame, count_drop=1, second frame emitted intact, count_tx=1.
- ctl FCS_INVALID=1, 60-byte frame, m_axis_tready toggled randomly (50%) -> byte order preserved, no byte lost or duplicated, tuser=1 only on the tlast beat.
- enable=0 with ctl pending -> ctl_tready and frame_tready stay 0; enable deasserted mid-frame -> current frame completes, next frame is held.
- Frame bytes present but ctl_tvalid=0 -> no frame byte consumed; rst_n asserted mid-frame -> all outputs and counters return to 0 the next cycle.
